imem_ctrl: RTL and testbench
============================

// Module: imem_ctrl
// PURPOSE
//  Instruction-memory responder serving the IF stage fetch port (imem_en/imem_addr -> imem_data).
//  Owns the instruction SRAM and a boot loader that streams the program in after reset.
//  Holds the core with start=0 until loading completes, then raises start and serves fetches.
//  One synchronous read per cycle, 1-cycle latency.
// PARAMETERS
//  INST_ADDR_WIDTH  8              word-address width; DEPTH = 2**INST_ADDR_WIDTH words
//  INST_DATA_WIDTH  32             instruction word width
//  NOP_INSTR        32'h0000_0000  word driven on imem_data when no valid read exists
// PORTS
//  clk         in   1                clock; all logic on posedge
//  rst         in   1                synchronous reset, active-high
//  ld_valid    in   1                loader word valid
//  ld_ready    out  1                loader may accept a word this cycle
//  ld_data     in   INST_DATA_WIDTH  instruction word to store
//  ld_last     in   1                this word is the final word of the program
//  ld_restart  in   1                1-cycle pulse; re-enter LOAD from RUN
//  start       out  1                program loaded; fetch port live (drives IF start)
//  load_count  out  INST_ADDR_WIDTH+1  words stored in the current load
//  imem_en     in   1                fetch request
//  imem_addr   in   INST_ADDR_WIDTH  fetch word address (PC[INST_ADDR_WIDTH+1:2])
//  imem_data   out  INST_DATA_WIDTH  fetched instruction, registered
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=LOAD, wr_ptr=0, load_count=0, start=0, ld_ready=0 for that cycle,
//   imem_data=NOP_INSTR. SRAM contents are not cleared. Reset mid-load or mid-run gives the same result.
//  FSM states: LOAD, RUN.
//   LOAD: ld_ready=1. A beat transfers when ld_valid&&ld_ready. It writes ld_data to mem[wr_ptr],
//    then increments wr_ptr and load_count.
//    LOAD->RUN when the transferring beat has ld_last=1, or when it writes address DEPTH-1.
//    In that same edge start<=1 and ld_ready<=0.
//    Any word offered after auto-termination at DEPTH-1 is not accepted (ld_ready=0).
//   RUN: ld_ready=0 and start=1. ld_restart=1 -> LOAD. On that edge wr_ptr<=0, load_count<=0, start<=0.
//    ld_restart is ignored in LOAD.
//  Fetch: in RUN with imem_en=1 at edge N, imem_data = mem[imem_addr] after edge N (valid in cycle N+1).
//   With imem_en=0, imem_data holds its previous value.
//   In LOAD, imem_data<=NOP_INSTR whenever imem_en=1, otherwise it holds.
//  Simultaneous events:
//   - ld_restart together with imem_en in RUN: restart wins and imem_data<=NOP_INSTR.
//   - Read of the address written on the final load edge: that read cannot occur, because start rises
//     only after the write.
//   - The SRAM is read-first (1R1W); same-cycle read/write of the same address is impossible by the FSM.
//  Width: imem_addr spans exactly DEPTH, so out-of-range is impossible.
//   load_count is INST_ADDR_WIDTH+1 bits so it can reach DEPTH.
//   wr_ptr wraps to 0 only through restart or reset.
// STRUCTURE
//  cpu_pkg: INST_ADDR_WIDTH, INST_DATA_WIDTH, INST_NOP constant, typedef enum logic {LOAD,RUN} imem_ld_state_e.
//  Sub-module imem_array: 1W1R synchronous array (we, waddr, wdata, re, raddr, rdata); infers BRAM.
//  imem_ctrl contains the FSM, wr_ptr/load_count counters, NOP muxing and the output hold register.
// TESTING
//  1) Reset, load 4 words 0x11,0x22,0x33,0x44 with last on word 4.
//     -> start=1 on the cycle after beat 4; load_count=4.
//     -> imem_en=1 at addrs 0..3 -> imem_data 0x11..0x44, one cycle later each.
//  2) Throttled loader (ld_valid toggling 1,0,1,0) for 3 words -> only valid beats are stored; load_count=3.
//  3) Fill all 256 words without ld_last -> auto RUN after word 255; ld_ready=0; a 257th offered word is dropped.
//     -> read addr 255 returns word 255.
//  4) imem_en=1 while in LOAD -> imem_data=NOP_INSTR.
//     In RUN, imem_en=0 for 3 cycles after a read of 0x22 -> imem_data stays 0x22.
//  5) In RUN, pulse ld_restart with imem_en=1 -> imem_data=NOP_INSTR, start=0, load_count=0.
//     Reload 0xAA at addr 0 -> read 0 returns 0xAA; addr 1 still returns 0x22.
//  6) Assert rst mid-load after 2 of 4 words -> start=0, load_count=0, ld_ready=0 during reset.
//     Reload of 1 word with last -> start=1.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared constants and types for the instruction-memory controller.
package imem_ctrl_pkg;
  localparam int INST_ADDR_WIDTH = 8;
  localparam int INST_DATA_WIDTH = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} imem_ld_state_e;
endpackage

// File: rtl/imem_ctrl_array.sv
// 1W1R synchronous instruction array, read-first; rdata holds while re=0.
module imem_array #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory with boot loader: streams the program in, then raises start and serves fetches.
module imem_ctrl #(
  parameter int INST_ADDR_WIDTH = imem_ctrl_pkg::INST_ADDR_WIDTH,
  parameter int INST_DATA_WIDTH = imem_ctrl_pkg::INST_DATA_WIDTH,
  parameter logic [INST_DATA_WIDTH-1:0] NOP_INSTR = INST_DATA_WIDTH'(imem_ctrl_pkg::INST_NOP)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [INST_DATA_WIDTH-1:0] ld_data,
  input  logic                       ld_last,
  input  logic                       ld_restart,
  output logic                       start,
  output logic [INST_ADDR_WIDTH:0]   load_count,
  input  logic                       imem_en,
  input  logic [INST_ADDR_WIDTH-1:0] imem_addr,
  output logic [INST_DATA_WIDTH-1:0] imem_data
);
  import imem_ctrl_pkg::*;

  localparam logic [INST_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  imem_ld_state_e               state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [INST_ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                         sel_q, sel_d;
  logic                         fire, done, restart, rd_en, nop_ev;
  logic [INST_DATA_WIDTH-1:0]   rdata;

  assign fire    = ld_ready && ld_valid;
  assign done    = fire && (ld_last || wr_ptr_q == LAST_ADDR);
  assign restart = (state_q == RUN) && ld_restart;
  assign rd_en   = (state_q == RUN) && imem_en && !restart;
  assign nop_ev  = imem_en && ((state_q == LOAD) || restart);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: if (done) state_d = RUN;
      RUN:  if (ld_restart) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    ld_ready = (state_q == LOAD) && !rst;
    start    = (state_q == RUN);
  end

  // wr_ptr saturates at the top address; only restart/reset brings it back to 0
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (restart) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (fire) begin
      cnt_d    = cnt_q + (INST_ADDR_WIDTH+1)'(1);
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? wr_ptr_q : wr_ptr_q + INST_ADDR_WIDTH'(1);
    end
  end

  // sel_q picks the array output register (which itself holds) or the NOP word
  always_comb begin
    sel_d = sel_q;
    if (rd_en)       sel_d = 1'b1;
    else if (nop_ev) sel_d = 1'b0;
  end

  imem_array #(.AW(INST_ADDR_WIDTH), .DW(INST_DATA_WIDTH)) u_array (
    .clk  (clk),
    .we   (fire),
    .waddr(wr_ptr_q),
    .wdata(ld_data),
    .re   (rd_en),
    .raddr(imem_addr),
    .rdata(rdata)
  );

  assign load_count = cnt_q;
  assign imem_data  = sel_q ? rdata : NOP_INSTR;
endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: load, throttled load, full fill, hold, restart and reset-mid-load.
module tb_imem_ctrl;
  logic        clk = 1'b0;
  logic        rst, ld_valid, ld_last, ld_restart, imem_en;
  logic        ld_ready, start;
  logic [31:0] ld_data, imem_data;
  logic [8:0]  load_count;
  logic [7:0]  imem_addr;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  imem_ctrl dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .ld_restart(ld_restart), .start(start), .load_count(load_count),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [31:0] d, input logic last);
    ld_valid = v; ld_data = d; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    imem_en = 1'b1; imem_addr = a;
    step();
    imem_en = 1'b0;
    chk(tag, imem_data, exp);
  endtask

  task automatic restart_pulse(input logic en);
    ld_restart = 1'b1; imem_en = en; imem_addr = 8'd0;
    step();
    ld_restart = 1'b0; imem_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ld_valid = 0; ld_last = 0; ld_restart = 0; imem_en = 0;
    ld_data = '0; imem_addr = '0;
    step(); step();
    chk("rst_start", start, 0);
    chk("rst_count", load_count, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_data", imem_data, 32'h0);
    rst = 1'b0;
    #1 chk("load_ready", ld_ready, 1);

    // 1) basic 4-word load and readback
    beat(1, 32'h11, 0); beat(1, 32'h22, 0); beat(1, 32'h33, 0);
    chk("t1_start_early", start, 0);
    beat(1, 32'h44, 1);
    chk("t1_start", start, 1);
    chk("t1_ready", ld_ready, 0);
    chk("t1_count", load_count, 4);
    rd(0, 32'h11, "t1_rd0"); rd(1, 32'h22, "t1_rd1");
    rd(2, 32'h33, "t1_rd2"); rd(3, 32'h44, "t1_rd3");

    // restart without fetch holds data; fetch in LOAD gives NOP
    restart_pulse(0);
    chk("t4_restart_hold", imem_data, 32'h44);
    chk("t4_restart_start", start, 0);
    imem_en = 1'b1; imem_addr = 8'd1;
    step(); imem_en = 1'b0;
    chk("t4_load_nop", imem_data, 32'h0);
    chk("t4_load_count", load_count, 0);

    // 2) throttled loader; ld_last on idle beats must be ignored
    beat(1, 32'h55, 0); beat(0, 32'hDEAD, 1);
    beat(1, 32'h66, 0); beat(0, 32'hBEEF, 1);
    chk("t2_not_done", start, 0);
    beat(1, 32'h77, 1);
    chk("t2_start", start, 1);
    chk("t2_count", load_count, 3);
    rd(0, 32'h55, "t2_rd0"); rd(1, 32'h66, "t2_rd1");
    rd(2, 32'h77, "t2_rd2"); rd(3, 32'h44, "t2_rd3_old");

    // 4) hold with imem_en=0 for 3 cycles
    rd(1, 32'h66, "t4_rd1");
    imem_addr = 8'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold", imem_data, 32'h66);
    end

    // 5) restart with a simultaneous fetch, reload one word
    restart_pulse(1);
    chk("t5_nop", imem_data, 32'h0);
    chk("t5_start", start, 0);
    chk("t5_count", load_count, 0);
    beat(1, 32'hAA, 1);
    chk("t5_start1", start, 1);
    chk("t5_count1", load_count, 1);
    rd(0, 32'hAA, "t5_rd0"); rd(1, 32'h66, "t5_rd1");

    // 3) fill all 256 words without ld_last
    restart_pulse(0);
    for (int i = 0; i < 256; i++) begin
      beat(1, 32'h1000 + i, 0);
      if (i == 254) chk("t3_start_early", start, 0);
    end
    chk("t3_start", start, 1);
    chk("t3_ready", ld_ready, 0);
    chk("t3_count", load_count, 256);
    beat(1, 32'hBAD, 0);
    chk("t3_drop_count", load_count, 256);
    rd(255, 32'h10FF, "t3_rd255");
    rd(0, 32'h1000, "t3_rd0");

    // 6) reset mid-load
    restart_pulse(0);
    beat(1, 32'hC1, 0); beat(1, 32'hC2, 0);
    chk("t6_count2", load_count, 2);
    rst = 1'b1; ld_valid = 1'b1; ld_data = 32'hC3;
    #1 chk("t6_ready_in_rst", ld_ready, 0);
    step();
    chk("t6_rst_start", start, 0);
    chk("t6_rst_count", load_count, 0);
    chk("t6_rst_ready", ld_ready, 0);
    rst = 1'b0; ld_valid = 1'b0;
    #1 chk("t6_count_after", load_count, 0);
    beat(1, 32'hD0, 1);
    chk("t6_start", start, 1);
    chk("t6_count1", load_count, 1);
    rd(0, 32'hD0, "t6_rd0"); rd(1, 32'hC2, "t6_rd1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
